// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Captures operands on accept, iterates WIDTH cycles, and returns the result with a one-cycle ready pulse.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_start_i,
    input  logic [1:0]       div_op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             div_res_ready_o,
    output logic [WIDTH-1:0] div_result_o,
    output logic             div_busy_o
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
        neg_if = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             ready_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;

    logic             accept_s;
    logic             signed_s;
    logic             dvd_neg_s;
    logic             dsr_neg_s;
    logic             special_s;
    logic [WIDTH-1:0] special_res_s;
    logic [WIDTH:0]   rem_ext_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] quo_nxt_s;
    logic [WIDTH-1:0] calc_res_s;

    assign accept_s  = (state_r == ST_IDLE) && div_start_i;
    assign signed_s  = ~div_op_i[0];
    assign dvd_neg_s = signed_s & dividend_i[WIDTH-1];
    assign dsr_neg_s = signed_s & divisor_i[WIDTH-1];

    // RISC-V defined results that bypass the iteration loop
    always_comb begin
        special_s     = 1'b0;
        special_res_s = ZERO_W;
        if (divisor_i == ZERO_W) begin
            special_s     = 1'b1;
            special_res_s = div_op_i[1] ? dividend_i : ONES_W;
        end else if (signed_s && (dividend_i == MIN_NEG_W) && (divisor_i == ONES_W)) begin
            special_s     = 1'b1;
            special_res_s = div_op_i[1] ? ZERO_W : MIN_NEG_W;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO_W;
        end
    end

    // One restoring step; the extra top bit keeps unsigned divisors above 2^(W-1) exact
    always_comb begin
        rem_ext_s  = {rem_r, dvd_r[WIDTH-1]};
        rem_sub_s  = rem_ext_s - {1'b0, dsr_r};
        ge_s       = (rem_ext_s >= {1'b0, dsr_r});
        rem_nxt_s  = ge_s ? rem_sub_s[WIDTH-1:0] : rem_ext_s[WIDTH-1:0];
        quo_nxt_s  = {dvd_r[WIDTH-2:0], ge_s};
        if (op_r[1]) begin
            calc_res_s = neg_if(neg_r_r, rem_nxt_s);
        end else begin
            calc_res_s = neg_if(neg_q_r, quo_nxt_s);
        end
    end

    // Control FSM, operand capture and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            op_r     <= 2'b00;
            dvd_r    <= ZERO_W;
            dsr_r    <= ZERO_W;
            rem_r    <= ZERO_W;
            cnt_r    <= CNT_ZERO;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            ready_r  <= 1'b0;
            result_r <= ZERO_W;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b0;
                    if (accept_s) begin
                        op_r    <= div_op_i;
                        dvd_r   <= neg_if(dvd_neg_s, dividend_i);
                        dsr_r   <= neg_if(dsr_neg_s, divisor_i);
                        rem_r   <= ZERO_W;
                        cnt_r   <= CNT_ZERO;
                        neg_q_r <= dvd_neg_s ^ dsr_neg_s;
                        neg_r_r <= dvd_neg_s;
                        busy_r  <= 1'b1;
                        if (special_s) begin
                            result_r <= special_res_s;
                            ready_r  <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_CALC;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    rem_r  <= rem_nxt_s;
                    dvd_r  <= quo_nxt_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    busy_r <= 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        result_r <= calc_res_s;
                        ready_r  <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        ready_r  <= 1'b0;
                        state_r  <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign div_res_ready_o = ready_r;
    assign div_result_o    = result_r;
    assign div_busy_o      = busy_r;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results, special cases, operand hold, abort.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start_i;
    logic [1:0]  div_op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        div_res_ready_o;
    logic [31:0] div_result_o;
    logic        div_busy_o;

    int checks;
    int failures;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start_i     (div_start_i),
        .div_op_i        (div_op_i),
        .dividend_i      (dividend_i),
        .divisor_i       (divisor_i),
        .div_res_ready_o (div_res_ready_o),
        .div_result_o    (div_result_o),
        .div_busy_o      (div_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request in cycle 0 and hold start until ready; optionally scramble operands after accept.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit scramble);
        int cyc;
        int ready_cnt;
        @(negedge clk);
        div_op_i    = op;
        dividend_i  = a;
        divisor_i   = b;
        div_start_i = 1'b1;
        cyc = 0;
        ready_cnt = 0;
        while (ready_cnt == 0 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (div_res_ready_o === 1'b1) ready_cnt++;
            if (scramble && cyc == 3) begin
                dividend_i = 32'h1234_5678;
                divisor_i  = 32'h0000_0003;
                div_op_i   = ~op;
            end
        end
        div_start_i = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_result"}, div_result_o, exp_res);
        check({tag, "_busy_done"}, {31'd0, div_busy_o}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_ready_width"}, {31'd0, div_res_ready_o}, 32'd0);
        check({tag, "_busy_idle"}, {31'd0, div_busy_o}, 32'd0);
        check({tag, "_result_hold"}, div_result_o, exp_res);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        div_start_i = 1'b0;
        div_op_i    = 2'b00;
        dividend_i  = 32'd0;
        divisor_i   = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, div_res_ready_o}, 32'd0);
        check("rst_busy", {31'd0, div_busy_o}, 32'd0);
        check("rst_result", div_result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_ready", {31'd0, div_res_ready_o}, 32'd0);
            check("idle_busy", {31'd0, div_busy_o}, 32'd0);
        end

        // Unsigned normal path
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 1'b0);
        run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 1'b0);

        // Signed normal path
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
        run_op("div_0_5", 2'b00, 32'd0, 32'd5, 32'd0, 33, 1'b0);

        // Special cases
        run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_op("divu_ovf_pat", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);

        // Operand hold and back-to-back
        run_op("hold_divu", 2'b01, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        run_op("b2b_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 33, 1'b0);
        run_op("b2b_10_4", 2'b01, 32'd10, 32'd4, 32'd2, 33, 1'b0);

        // Abort in CALC cycle 10
        @(negedge clk);
        div_op_i    = 2'b01;
        dividend_i  = 32'd100;
        divisor_i   = 32'd7;
        div_start_i = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("abort_busy_pre", {31'd0, div_busy_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, div_res_ready_o}, 32'd0);
        check("abort_busy", {31'd0, div_busy_o}, 32'd0);
        check("abort_result", div_result_o, 32'd0);
        div_start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_abort_idle", {31'd0, div_busy_o}, 32'd0);
        run_op("post_abort_8_2", 2'b01, 32'd8, 32'd2, 32'd4, 33, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
